// File: rtl/multi_mode_watch.sv
// multi_mode_watch: free-running h/m/s time-of-day counter with a configurable
// tick divisor, a set mode (field select, increment, decrement, clear), a
// selected-field blink strobe, 12/24 h display conversion and a 1 Hz tick.
// Optional alarm comparator: define MULTI_MODE_WATCH_ALARM_EN to build it in.
// With the macro undefined the alarm ports and logic do not exist.

module multi_mode_watch #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       mode_pulse,
    input  logic       sel_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    input  logic       clear_pulse,
    input  logic       mode_12h,
`ifdef MULTI_MODE_WATCH_ALARM_EN
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm_ring,
`endif
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic       set_mode,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic       tick_1hz
);

    // Prescaler width follows the divisor; it is never set independently.
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_HALF = CNT_W'(TICK_DIV / 2);

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Field-select encoding; value 3 is never entered.
    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             set_mode_q, set_mode_d;
    logic [1:0]       field_sel_q, field_sel_d;
    logic             tick_q, tick_d;
    logic             pre_term;
    logic             edit_inc;
    logic             edit_dec;

    assign pre_term = (pre_q == PRE_TERM);
    assign edit_inc = inc_pulse && !dec_pulse;
    assign edit_dec = dec_pulse && !inc_pulse;

    // Prescaler, run/set toggle, field selection and the registered 1 Hz tick.
    always_comb begin
        pre_d       = pre_q;
        set_mode_d  = set_mode_q;
        field_sel_d = field_sel_q;
        tick_d      = 1'b0;

        if (mode_pulse) begin
            pre_d = '0;
        end else if (pre_term) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        if (!set_mode_q) begin
            tick_d = pre_term;
        end

        if (set_mode_q && sel_pulse) begin
            if (field_sel_q == FIELD_HOUR) begin
                field_sel_d = FIELD_SEC;
            end else begin
                field_sel_d = field_sel_q + 2'd1;
            end
        end

        if (mode_pulse) begin
            set_mode_d = !set_mode_q;
            if (set_mode_q) begin
                field_sel_d = FIELD_SEC;
            end
        end
    end

    // Time fields: carry chain on run-mode ticks, per-field edits in set mode.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;

        if (!set_mode_q) begin
            if (pre_term) begin
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d  = '0;
                        hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end else if (clear_pulse) begin
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (edit_inc) begin
            case (field_sel_q)
                FIELD_SEC:  sec_d  = (sec_q  == SEC_MAX)  ? 6'd0 : sec_q  + 6'd1;
                FIELD_MIN:  min_d  = (min_q  == MIN_MAX)  ? 6'd0 : min_q  + 6'd1;
                FIELD_HOUR: hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                default: ;
            endcase
        end else if (edit_dec) begin
            case (field_sel_q)
                FIELD_SEC:  sec_d  = (sec_q  == 6'd0) ? SEC_MAX  : sec_q  - 6'd1;
                FIELD_MIN:  min_d  = (min_q  == 6'd0) ? MIN_MAX  : min_q  - 6'd1;
                FIELD_HOUR: hour_d = (hour_q == 5'd0) ? HOUR_MAX : hour_q - 5'd1;
                default: ;
            endcase
        end
    end

    // All watch state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            set_mode_q  <= 1'b0;
            field_sel_q <= FIELD_SEC;
            tick_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            set_mode_q  <= set_mode_d;
            field_sel_q <= field_sel_d;
            tick_q      <= tick_d;
        end
    end

    // Display hour: 0 shows as 12, 13..23 fold down by 12 in 12 h mode.
    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign pm        = (hour_q >= 5'd12);
    assign set_mode  = set_mode_q;
    assign field_sel = field_sel_q;
    assign blink     = set_mode_q && (pre_q < PRE_HALF);
    assign tick_1hz  = tick_q;

`ifdef MULTI_MODE_WATCH_ALARM_EN
    logic alarm_ring_q, alarm_ring_d;
    logic alarm_hit;
    logic alarm_ack;

    // A hit is judged on the time produced by this cycle's run-mode tick, so
    // set-mode edits can never ring the alarm.
    assign alarm_hit = !set_mode_q && pre_term && alarm_arm &&
                       (hour_d == alarm_hour) && (min_d == alarm_min) &&
                       (sec_d == 6'd0);
    assign alarm_ack = !alarm_arm || mode_pulse || inc_pulse || dec_pulse || sel_pulse;

    // Ring latch: set on a hit, held until disarmed or acknowledged by a button.
    always_comb begin
        alarm_ring_d = alarm_ring_q;
        if (alarm_hit) begin
            alarm_ring_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_ring_d = 1'b0;
        end
    end

    // Alarm flop shares the watch reset.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            alarm_ring_q <= 1'b0;
        end else begin
            alarm_ring_q <= alarm_ring_d;
        end
    end

    assign alarm_ring = alarm_ring_q;
`endif

endmodule

// File: tb/tb_multi_mode_watch.sv
// Testbench for multi_mode_watch with TICK_DIV = 10: table of set-mode edits,
// hand-written multi-cycle sequences, and a randomized run against a
// seconds-of-day reference model.

module tb_multi_mode_watch;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       mode_pulse = 1'b0;
    logic       sel_pulse = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic       clear_pulse = 1'b0;
    logic       mode_12h = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       set_mode;
    logic [1:0] field_sel;
    logic       blink;
    logic       tick_1hz;
`ifdef MULTI_MODE_WATCH_ALARM_EN
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min = 6'd1;
    logic       alarm_arm = 1'b1;
    logic       alarm_ring;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: whole time of day as seconds since midnight.
    int m_t;
    int m_pre;
    int m_fsel;
    bit m_set;
    bit m_tick;
    bit m_ring;

    typedef struct {
        bit mo;
        bit se;
        bit in_;
        bit de;
        bit cl;
        bit m12;
        int es;
        int em;
        int eh;
        int efs;
        int eset;
        int ehd;
        int epm;
    } vec_t;

    vec_t vq[$];

    multi_mode_watch #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .mode_pulse (mode_pulse),
        .sel_pulse  (sel_pulse),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .clear_pulse(clear_pulse),
        .mode_12h   (mode_12h),
`ifdef MULTI_MODE_WATCH_ALARM_EN
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_arm  (alarm_arm),
        .alarm_ring (alarm_ring),
`endif
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .hour_disp  (hour_disp),
        .pm         (pm),
        .set_mode   (set_mode),
        .field_sel  (field_sel),
        .blink      (blink),
        .tick_1hz   (tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_t = 0;
        m_pre = 0;
        m_fsel = 0;
        m_set = 1'b0;
        m_tick = 1'b0;
        m_ring = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int h;
        int m;
        int s;
        int d;
        bit term;
        term = (m_pre == TD - 1);
        m_tick = 1'b0;
        if (!m_set) begin
            if (term) begin
                m_t = (m_t + 1) % 86400;
                m_tick = 1'b1;
            end
        end else begin
            if (clear_pulse) begin
                m_t = 0;
            end else if (inc_pulse != dec_pulse) begin
                h = m_t / 3600;
                m = (m_t / 60) % 60;
                s = m_t % 60;
                d = inc_pulse ? 1 : -1;
                if (m_fsel == 0) s = (s + d + 60) % 60;
                if (m_fsel == 1) m = (m + d + 60) % 60;
                if (m_fsel == 2) h = (h + d + 24) % 24;
                m_t = h * 3600 + m * 60 + s;
            end
            if (sel_pulse) m_fsel = (m_fsel + 1) % 3;
        end
`ifdef MULTI_MODE_WATCH_ALARM_EN
        if (!m_set && term && alarm_arm && (m_t % 60 == 0) &&
            (m_t / 60 == int'(alarm_hour) * 60 + int'(alarm_min))) begin
            m_ring = 1'b1;
        end else if (!alarm_arm || mode_pulse || inc_pulse || dec_pulse || sel_pulse) begin
            m_ring = 1'b0;
        end
`endif
        if (mode_pulse) begin
            if (m_set) m_fsel = 0;
            m_set = !m_set;
            m_pre = 0;
        end else begin
            m_pre = term ? 0 : m_pre + 1;
        end
    endtask

    function automatic logic [31:0] expVec();
        int h;
        int hd;
        logic [31:0] v;
        h = m_t / 3600;
        hd = mode_12h ? ((h + 11) % 12) + 1 : h;
        v = {4'd0, 6'(m_t % 60), 6'((m_t / 60) % 60), 5'(h), 5'(hd), (h >= 12),
             m_set, 2'(m_fsel), (m_set && (m_pre < TD / 2)), m_tick};
`ifdef MULTI_MODE_WATCH_ALARM_EN
        v[28] = m_ring;
`endif
        return v;
    endfunction

    function automatic logic [31:0] dutVec();
        logic [31:0] v;
        v = {4'd0, sec, min, hour, hour_disp, pm, set_mode, field_sel, blink, tick_1hz};
`ifdef MULTI_MODE_WATCH_ALARM_EN
        v[28] = alarm_ring;
`endif
        return v;
    endfunction

    // Drive one cycle of pulses at a negedge, release them after the edge,
    // and return at the following negedge ready for sampling.
    task automatic applyStimulus(input bit mo, input bit se, input bit in_, input bit de, input bit cl);
        mode_pulse = mo;
        sel_pulse = se;
        inc_pulse = in_;
        dec_pulse = de;
        clear_pulse = cl;
        modelStep();
        @(posedge clk);
        #1;
        mode_pulse = 1'b0;
        sel_pulse = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        clear_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        reset_p = 1'b1;
        mode_pulse = 1'b0;
        sel_pulse = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        clear_pulse = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset_p = 1'b0;
    endtask

    function automatic logic [31:0] timeVec(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] dutTime();
        return {15'd0, hour, min, sec};
    endfunction

    initial begin
        logic [31:0] rowExp;
        logic [31:0] rowAct;
        logic [9:0]  blinkPat;
        int          tickCount;
        int          tickMisplaced;

        // Rows: pulses mode,sel,inc,dec,clear, level mode_12h | sec,min,hour,field_sel,set_mode,hour_disp,pm
        vq.push_back(vec_t'{1,0,0,0,0,1,  0, 0, 0,0,1,12,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,1,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,2,1, 0,0});
        vq.push_back(vec_t'{0,0,0,1,0,1,  0, 0,23,2,1,11,1});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0,23,0,1,23,1});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0,23,1,1,23,1});
        vq.push_back(vec_t'{0,0,0,1,0,0,  0,59,23,1,1,23,1});
        vq.push_back(vec_t'{0,0,1,0,0,0,  0, 0,23,1,1,23,1});
        vq.push_back(vec_t'{0,0,1,1,0,0,  0, 0,23,1,1,23,1});
        vq.push_back(vec_t'{0,0,0,1,0,0,  0,59,23,1,1,23,1});
        vq.push_back(vec_t'{0,1,1,0,0,0,  0, 0,23,2,1,23,1});
        vq.push_back(vec_t'{0,0,1,0,0,0,  0, 0, 0,2,1, 0,0});
        vq.push_back(vec_t'{0,0,0,1,0,0,  0, 0,23,2,1,23,1});
        vq.push_back(vec_t'{0,0,1,0,1,0,  0, 0, 0,2,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,0,1, 0,0});
        vq.push_back(vec_t'{0,0,0,1,0,0, 59, 0, 0,0,1, 0,0});
        vq.push_back(vec_t'{0,0,1,0,0,0,  0, 0, 0,0,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,1,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,2,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,0,1, 0,0});
        vq.push_back(vec_t'{0,1,0,0,0,0,  0, 0, 0,1,1, 0,0});
        vq.push_back(vec_t'{1,0,0,0,0,0,  0, 0, 0,0,0, 0,0});

        // Reset state.
        doReset();
        checkOutput("reset_state", dutVec(), 32'd0);
        mode_12h = 1'b1;
        #1;
        checkOutput("reset_hour_disp_12h", {27'd0, hour_disp}, 32'd12);

        // Table of set-mode edits.
        foreach (vq[i]) begin
            mode_12h = vq[i].m12;
            applyStimulus(vq[i].mo, vq[i].se, vq[i].in_, vq[i].de, vq[i].cl);
            rowExp = {6'd0, 6'(vq[i].es), 6'(vq[i].em), 5'(vq[i].eh), 2'(vq[i].efs),
                      1'(vq[i].eset), 5'(vq[i].ehd), 1'(vq[i].epm)};
            rowAct = {6'd0, sec, min, hour, field_sel, set_mode, hour_disp, pm};
            checkOutput($sformatf("vec[%0d]", i), rowAct, rowExp);
        end

        // Hours 12 and 13 in both display modes.
        mode_12h = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("hour12_24h", {26'd0, hour_disp, pm}, {26'd0, 5'd12, 1'b1});
        mode_12h = 1'b1;
        #1;
        checkOutput("hour12_12h", {26'd0, hour_disp, pm}, {26'd0, 5'd12, 1'b1});
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("hour13_12h", {21'd0, hour, hour_disp, pm}, {21'd0, 5'd13, 5'd1, 1'b1});
        mode_12h = 1'b0;

        // Blink: five cycles high, five low after entering set mode.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("blink_run_low", {31'd0, blink}, 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            blinkPat[k] = blink;
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("blink_pattern", {22'd0, blinkPat}, {22'd0, 10'b0000011111});

        // Preload 23:59:58 and roll over midnight.
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("preload_time", dutTime(), timeVec(23, 59, 58));
        checkOutput("preload_pm_fsel", {29'd0, pm, field_sel}, {29'd0, 1'b1, 2'd0});
        idle(10);
        checkOutput("rollover_59", dutTime(), timeVec(23, 59, 59));
        idle(10);
        checkOutput("rollover_00", {10'd0, pm, hour, min, sec, 5'd0}, 32'd0);

        // 600 cycles of run mode from reset.
        doReset();
        tickCount = 0;
        tickMisplaced = 0;
        for (int n = 1; n <= 600; n++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (tick_1hz) tickCount++;
            if (tick_1hz !== ((n % TD) == 0)) tickMisplaced++;
            if (n == 590) checkOutput("run_590", dutTime(), timeVec(0, 0, 59));
        end
        checkOutput("run_600", dutTime(), timeVec(0, 1, 0));
        checkOutput("tick_count", tickCount, 32'd60);
        checkOutput("tick_placement", tickMisplaced, 32'd0);

        // Reset asserted mid-count clears immediately, then counting restarts.
        idle(35);
        checkOutput("pre_midreset", dutTime(), timeVec(0, 1, 3));
        #2;
        reset_p = 1'b1;
        #1;
        checkOutput("midreset_async", dutVec(), 32'd0);
        @(negedge clk);
        reset_p = 1'b0;
        modelReset();
        idle(9);
        checkOutput("restart_9", {25'd0, sec, tick_1hz}, 32'd0);
        idle(1);
        checkOutput("restart_10", {25'd0, sec, tick_1hz}, {25'd0, 6'd1, 1'b1});

`ifdef MULTI_MODE_WATCH_ALARM_EN
        // Alarm at 00:01, armed, then acknowledged by inc; then disarmed run.
        alarm_hour = 5'd0;
        alarm_min = 6'd1;
        alarm_arm = 1'b1;
        doReset();
        idle(599);
        checkOutput("alarm_before", {31'd0, alarm_ring}, 32'd0);
        idle(1);
        checkOutput("alarm_rise", {31'd0, alarm_ring}, 32'd1);
        idle(3);
        checkOutput("alarm_hold", {31'd0, alarm_ring}, 32'd1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("alarm_ack_inc", {31'd0, alarm_ring}, 32'd0);
        alarm_arm = 1'b0;
        doReset();
        idle(600);
        checkOutput("alarm_disarmed", {31'd0, alarm_ring}, 32'd0);
        alarm_arm = 1'b1;
`endif

        // Randomized run against the reference model.
        doReset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
`ifdef MULTI_MODE_WATCH_ALARM_EN
            if ($urandom_range(0, 199) == 0) begin
                alarm_hour = 5'($urandom_range(0, 2));
                alarm_min = 6'($urandom_range(0, 5));
            end
            alarm_arm = ($urandom_range(0, 7) != 0);
`endif
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 15) == 0);
            checkOutput("random", dutVec(), expVec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
